// File: rtl/decoder_pkg.sv
// Shared types and sizes for the sequential 3-to-8 decoder.
// State encoding always includes GAP so builds with and without DECODER_GAP_EN share one enum.
package decoder_pkg;

  localparam int CODE_W     = 3;
  localparam int ONEHOT_W   = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [ONEHOT_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
    logic [ONEHOT_W-1:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_3_8_seq_if.sv
// Code intake handshake plus one-hot strobe outputs of decoder_3_8_seq.
// master = producer/consumer side, slave = decoder side.
interface decoder_3_8_seq_if;
  logic                            en;
  logic                            in_valid;
  logic                            in_ready;
  logic [decoder_pkg::CODE_W-1:0]   in_code;
  logic [decoder_pkg::ONEHOT_W-1:0] out;
  logic                            out_valid;
  logic                            strobe_done;

  modport master (
    output en, in_valid, in_code,
    input  in_ready, out, out_valid, strobe_done
  );

  modport slave (
    input  en, in_valid, in_code,
    output in_ready, out, out_valid, strobe_done
  );
endinterface

// File: rtl/decoder_3_8_seq_code_fifo.sv
// Small CODE_W-wide FIFO buffering codes between intake and the strobe FSM.
// Head is visible combinationally so the FSM can pop and load in the same cycle.
module code_fifo
  import decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [CODE_W-1:0] din,
  input  logic              pop,
  output logic [CODE_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CODE_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               do_push, do_pop;

  assign full    = (count_reg == COUNT_W'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + COUNT_W'(1);
        2'b01:   count_reg <= count_reg - COUNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/decoder_3_8_seq.sv
// Sequential 3-to-8 decoder: queued codes replayed as one-hot strobes held HOLD_CYCLES cycles.
// Optional macro DECODER_GAP_EN inserts one idle cycle after every strobe.
module decoder_3_8_seq
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  decoder_3_8_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ONEHOT_W-1:0] onehot_reg, onehot_next;
  logic                push, pop;
  logic [CODE_W-1:0]   head;
  logic                fifo_full, fifo_empty;

  assign bus.in_ready    = bus.en && !fifo_full;
  assign push            = bus.in_valid && bus.in_ready;
  assign bus.out         = onehot_reg;
  assign bus.out_valid   = |onehot_reg;
  assign bus.strobe_done = (state_reg == DRIVE) && (cnt_reg == '0);

  code_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.in_code),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      onehot_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      onehot_reg <= onehot_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    onehot_next = onehot_reg;
    pop         = 1'b0;
    case (state_reg)
      DRIVE: begin
        if (!bus.en) begin
          // Abort: the in-flight strobe is dropped, queued codes stay put.
          state_next  = IDLE;
          cnt_next    = '0;
          onehot_next = '0;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
`ifdef DECODER_GAP_EN
          state_next  = GAP;
          onehot_next = '0;
`else
          if (!fifo_empty) begin
            pop         = 1'b1;
            onehot_next = onehot_of(head);
            cnt_next    = HOLD_LOAD;
          end else begin
            state_next  = IDLE;
            onehot_next = '0;
          end
`endif
        end
      end
      default: begin
        // IDLE and GAP both drive zero and may start the next strobe.
        state_next  = IDLE;
        cnt_next    = '0;
        onehot_next = '0;
        if (bus.en && !fifo_empty) begin
          pop         = 1'b1;
          onehot_next = onehot_of(head);
          cnt_next    = HOLD_LOAD;
          state_next  = DRIVE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_3_8_seq.sv
// Scoreboard bench for decoder_3_8_seq: accepted codes queue expected strobes, a monitor checks them.
// Directed phases cover latency, contiguity, abort, reset and HOLD_CYCLES=1.
module tb_decoder_3_8_seq;
  import decoder_pkg::*;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   exp_q[$];
  int   run_len = 0;
  logic [7:0] run_val = '0;
  logic prev_en = 1'b0;
  bit   gap_due = 0;

  decoder_3_8_seq_if ifc ();
  decoder_3_8_seq_if ifc1 ();

  decoder_3_8_seq #(.HOLD_CYCLES(HOLD)) dut (.clk(clk), .rst(rst), .bus(ifc));
  decoder_3_8_seq #(.HOLD_CYCLES(1))    dut1 (.clk(clk), .rst(rst), .bus(ifc1));

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_onehot(input int code);
    return 8'(2 ** code);
  endfunction

  function void chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function void fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=no_event", name);
  endfunction

  // Monitor + intake sampler; inputs only change just after posedge, so negedge sees what the next edge sees.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      run_len = 0;
      gap_due = 0;
      prev_en = 1'b0;
    end else begin
      chk_eq("out_valid", int'(ifc.out_valid), int'(ifc.out != 8'h00));
      chk_eq("onehot", int'($countones(ifc.out) <= 1), 1);
`ifdef DECODER_GAP_EN
      if (gap_due) chk_eq("gap_zero", int'(ifc.out), 0);
`endif
      gap_due = 0;
      if (run_len > 0 && ifc.out != run_val) begin
        chk_eq("abort_en_low", int'(prev_en), 0);
        chk_eq("abort_short", int'(run_len < HOLD), 1);
        if (exp_q.size() == 0) fail_now("abort_queue_empty");
        else chk_eq("abort_code", int'(run_val), int'(ref_onehot(exp_q.pop_front())));
        run_len = 0;
      end
      if (ifc.out != 8'h00) begin
        if (run_len == 0) run_val = ifc.out;
        run_len++;
      end
      if (ifc.strobe_done) begin
        if (exp_q.size() == 0) fail_now("strobe_unexpected");
        else begin
          chk_eq("strobe_code", int'(ifc.out), int'(ref_onehot(exp_q.pop_front())));
          chk_eq("strobe_len", run_len, HOLD);
        end
        run_len = 0;
        gap_due = 1;
      end
      prev_en = ifc.en;
      if (ifc.in_valid && ifc.in_ready) exp_q.push_back(int'(ifc.in_code));
    end
  end

  task automatic push_code(input int code);
    ifc.in_valid = 1'b1;
    ifc.in_code  = 3'(code);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_now("push_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && run_len == 0 && ifc.out == 8'h00) done = 1;
    end
    chk_eq("drain", int'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_o[3];
    bit         exp_d[3];
    int         n, replays, first, last, dones;
    bit         saw_full, seen;

    rst = 1'b1;
    ifc.en = 1'b0;  ifc.in_valid = 1'b0;  ifc.in_code = '0;
    ifc1.en = 1'b1; ifc1.in_valid = 1'b0; ifc1.in_code = '0;
    #12;
    chk_eq("rst_out", int'(ifc.out), 0);
    chk_eq("rst_out_valid", int'(ifc.out_valid), 0);
    chk_eq("rst_strobe_done", int'(ifc.strobe_done), 0);
    chk_eq("rst_in_ready_en0", int'(ifc.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ifc.en = 1'b1;
    #1;
    chk_eq("in_ready_after_rst", int'(ifc.in_ready), 1);
    @(posedge clk); #1;

    // Single code: one-edge latency then exactly HOLD cycles
    ifc.in_valid = 1'b1;
    ifc.in_code  = 3'd5;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk_eq("t1_latency_out", int'(ifc.out), 0);
    for (int i = 1; i <= HOLD; i++) begin
      @(negedge clk);
      chk_eq("t1_out", int'(ifc.out), 8'h20);
      chk_eq("t1_done", int'(ifc.strobe_done), int'(i == HOLD));
    end
    @(negedge clk);
    chk_eq("t1_out_after", int'(ifc.out), 0);
    @(posedge clk); #1;

    // Back-to-back codes
    first = -1; last = -1; dones = 0; saw_full = 0;
    fork
      begin
        push_code(0);
        push_code(7);
        push_code(3);
        ifc.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (!ifc.in_ready) saw_full = 1;
          if (ifc.out != 8'h00) begin
            if (first < 0) first = c;
            last = c;
          end
          if (ifc.strobe_done) dones++;
        end
      end
    join
`ifdef DECODER_GAP_EN
    chk_eq("b2b_span", last - first + 1, 3 * HOLD + 2);
`else
    chk_eq("b2b_span", last - first + 1, 3 * HOLD);
`endif
    chk_eq("b2b_dones", dones, 3);
    chk_eq("b2b_full_seen", int'(saw_full), 1);
    wait_drain(50);

    // Abort mid-strobe with a code queued
    push_code(4);
    push_code(1);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk_eq("abort_active", int'(ifc.out), 8'h10);
    @(posedge clk); #1;
    ifc.en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_eq("abort_out", int'(ifc.out), 0);
    chk_eq("abort_out_valid", int'(ifc.out_valid), 0);
    chk_eq("abort_in_ready", int'(ifc.in_ready), 0);
    @(posedge clk); #1;
    ifc.en = 1'b1;
    n = 0; replays = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifc.out == 8'h02) n++;
      if (ifc.out == 8'h10) replays++;
    end
    chk_eq("abort_next_len", n, HOLD);
    chk_eq("abort_no_replay", replays, 0);
    wait_drain(50);

    // Randomized traffic with occasional enable drops
    for (int c = 0; c < 400; c++) begin
      ifc.en       = ($urandom_range(0, 7) != 0);
      ifc.in_valid = 1'($urandom_range(0, 1));
      ifc.in_code  = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    ifc.en = 1'b1;
    wait_drain(200);

    // HOLD_CYCLES = 1 instance
`ifdef DECODER_GAP_EN
    exp_o = '{8'h04, 8'h00, 8'h40};
    exp_d = '{1'b1, 1'b0, 1'b1};
`else
    exp_o = '{8'h04, 8'h40, 8'h00};
    exp_d = '{1'b1, 1'b1, 1'b0};
`endif
    ifc1.in_valid = 1'b1;
    ifc1.in_code  = 3'd2;
    @(posedge clk); #1;
    ifc1.in_code  = 3'd6;
    @(posedge clk); #1;
    ifc1.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("h1_out", int'(ifc1.out), int'(exp_o[i]));
      chk_eq("h1_done", int'(ifc1.strobe_done), int'(exp_d[i]));
    end
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset mid-strobe with FIFO full
    push_code(3);
    push_code(6);
    push_code(1);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk_eq("full_in_ready", int'(ifc.in_ready), 0);
    chk_eq("full_out", int'(ifc.out), 8'h08);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_out", int'(ifc.out), 0);
    chk_eq("arst_out_valid", int'(ifc.out_valid), 0);
    chk_eq("arst_strobe_done", int'(ifc.strobe_done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_eq("post_rst_idle", int'(ifc.out), 0);
    end
    chk_eq("post_rst_in_ready", int'(ifc.in_ready), 1);
    @(posedge clk); #1;
    push_code(2);
    ifc.in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      if (ifc.out != 8'h00) begin
        seen = 1;
        chk_eq("post_rst_head", int'(ifc.out), 8'h04);
      end
    end
    chk_eq("post_rst_strobe_seen", int'(seen), 1);
    wait_drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
